// File: rtl/serial_deser_5bit.sv
// Serial-to-parallel frame receiver: start bit 1, DATA_W data bits MSB first, optional even parity, stop bit 0.
// Define SERIAL_DESER_PARITY_EN to compile in the parity bit and the par_err check.
module serial_deser_5bit #(
   parameter int DATA_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              sin_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun,
   output logic              par_err
);

   localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef SERIAL_DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  shreg;
   logic               last_bit;
   logic               stop_edge;
   logic               par_bad;
   logic               good;
   logic               load;

   assign last_bit = (cnt == CNT_W'(DATA_W - 1));

   // NOTE: reset is synchronous, so it appears only inside the clocked branch, never in the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: next-state is defaulted to the current state first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      if (sin_en) begin
         case (state)
            IDLE:    if (sin) state_nx = DATA;
            DATA:    if (last_bit) begin
`ifdef SERIAL_DESER_PARITY_EN
               state_nx = PARITY;
`else
               state_nx = STOP;
`endif
            end
`ifdef SERIAL_DESER_PARITY_EN
            PARITY:  state_nx = STOP;
`endif
            STOP:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

`ifdef SERIAL_DESER_PARITY_EN
   logic par_bit;
`endif

   always_comb begin
      busy      = (state != IDLE);
      stop_edge = sin_en && (state == STOP);
`ifdef SERIAL_DESER_PARITY_EN
      par_bad   = ^{shreg, par_bit};
`else
      par_bad   = 1'b0;
`endif
      // A bad stop bit takes precedence over a parity mismatch.
      good      = stop_edge && !sin && !par_bad;
      load      = good && (!dout_valid || dout_ready);
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         shreg      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (sin_en && state == IDLE && sin) cnt <= '0;
         if (sin_en && state == DATA) begin
            shreg <= {shreg[DATA_W-2:0], sin};
            cnt   <= cnt + CNT_W'(1);
         end
         frame_err <= stop_edge && sin;
         if (load) begin
            dout       <= shreg;
            dout_valid <= 1'b1;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
         if (good && dout_valid && !dout_ready) overrun <= 1'b1;
      end
   end

`ifdef SERIAL_DESER_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par_bit <= 1'b0;
         par_err <= 1'b0;
      end else begin
         if (sin_en && state == PARITY) par_bit <= sin;
         par_err <= stop_edge && !sin && par_bad;
      end
   end
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser_5bit.sv
// Directed bench for serial_deser_5bit: per-cycle vector table for the plain frame format,
// then hand-written sequences for back-pressure, strobe gaps, mid-frame reset and parity.
module tb_serial_deser_5bit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sin = 1'b0;
   logic       sin_en = 1'b0;
   logic       dout_ready = 1'b0;
   logic [4:0] dout;
   logic       dout_valid;
   logic       busy;
   logic       frame_err;
   logic       overrun;
   logic       par_err;

   int n_pass  = 0;
   int n_total = 0;

   serial_deser_5bit #(.DATA_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_en     (sin_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .par_err    (par_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       sin;
      logic       sin_en;
      logic       rdy;
      logic [4:0] dout;
      logic       valid;
      logic       busy;
      logic       ferr;
      logic       ovr;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // One clock edge; outputs are then examined 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      sin    = b;
      sin_en = 1'b1;
      step();
   endtask

   // Start, data MSB first, parity (when compiled in, optionally corrupted), stop.
   task automatic send_frame(input logic [4:0] d, input logic stop, input logic bad_par);
      send_bit(1'b1);
      for (int i = 4; i >= 0; i--) send_bit(d[i]);
`ifdef SERIAL_DESER_PARITY_EN
      send_bit((^d) ^ bad_par);
`else
      if (bad_par) $display("note: parity not compiled in");
`endif
      send_bit(stop);
   endtask

`ifndef SERIAL_DESER_PARITY_EN
   vec_t tbl[25];
`endif

   initial begin
      logic [4:0] d;

`ifndef SERIAL_DESER_PARITY_EN
      //           rst  sin  en   rdy  dout      vld  busy ferr ovr
      tbl[0]  = '{1'b1,1'b0,1'b1,1'b1,5'b00000,1'b0,1'b0,1'b0,1'b0};
      // basic frame 1,10110,0
      tbl[1]  = '{1'b0,1'b1,1'b1,1'b1,5'b00000,1'b0,1'b1,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b1,1'b1,1'b1,5'b00000,1'b0,1'b1,1'b0,1'b0};
      tbl[3]  = '{1'b0,1'b0,1'b1,1'b1,5'b00000,1'b0,1'b1,1'b0,1'b0};
      tbl[4]  = '{1'b0,1'b1,1'b1,1'b1,5'b00000,1'b0,1'b1,1'b0,1'b0};
      tbl[5]  = '{1'b0,1'b1,1'b1,1'b1,5'b00000,1'b0,1'b1,1'b0,1'b0};
      tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,5'b00000,1'b0,1'b1,1'b0,1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,5'b10110,1'b1,1'b0,1'b0,1'b0};
      tbl[8]  = '{1'b0,1'b0,1'b1,1'b1,5'b10110,1'b0,1'b0,1'b0,1'b0};
      // same frame with bad stop bit
      tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[10] = '{1'b0,1'b1,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[11] = '{1'b0,1'b0,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[12] = '{1'b0,1'b1,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[13] = '{1'b0,1'b1,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[14] = '{1'b0,1'b0,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[15] = '{1'b0,1'b1,1'b1,1'b1,5'b10110,1'b0,1'b0,1'b1,1'b0};
      tbl[16] = '{1'b0,1'b0,1'b1,1'b1,5'b10110,1'b0,1'b0,1'b0,1'b0};
      // following frame 1,00011,0
      tbl[17] = '{1'b0,1'b1,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[18] = '{1'b0,1'b0,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[19] = '{1'b0,1'b0,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[20] = '{1'b0,1'b0,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[21] = '{1'b0,1'b1,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[22] = '{1'b0,1'b1,1'b1,1'b1,5'b10110,1'b0,1'b1,1'b0,1'b0};
      tbl[23] = '{1'b0,1'b0,1'b1,1'b1,5'b00011,1'b1,1'b0,1'b0,1'b0};
      tbl[24] = '{1'b0,1'b0,1'b1,1'b1,5'b00011,1'b0,1'b0,1'b0,1'b0};

      for (int i = 0; i < 25; i++) begin
         rst        = tbl[i].rst;
         sin        = tbl[i].sin;
         sin_en     = tbl[i].sin_en;
         dout_ready = tbl[i].rdy;
         step();
         check($sformatf("vec%0d dout", i),       32'(dout),       32'(tbl[i].dout));
         check($sformatf("vec%0d dout_valid", i), 32'(dout_valid), 32'(tbl[i].valid));
         check($sformatf("vec%0d busy", i),       32'(busy),       32'(tbl[i].busy));
         check($sformatf("vec%0d frame_err", i),  32'(frame_err),  32'(tbl[i].ferr));
         check($sformatf("vec%0d overrun", i),    32'(overrun),    32'(tbl[i].ovr));
         check($sformatf("vec%0d par_err", i),    32'(par_err),    32'(0));
      end
      rst = 1'b0;
`endif

      // Back-pressure: two back-to-back frames with the consumer stalled.
      dout_ready = 1'b0;
      do_reset();
      send_frame(5'b10110, 1'b0, 1'b0);
      check("bp first valid",   32'(dout_valid), 32'(1));
      check("bp first dout",    32'(dout),       32'(5'b10110));
      check("bp first overrun", 32'(overrun),    32'(0));
      send_frame(5'b01001, 1'b0, 1'b0);
      check("bp held dout",     32'(dout),       32'(5'b10110));
      check("bp held valid",    32'(dout_valid), 32'(1));
      check("bp overrun set",   32'(overrun),    32'(1));
      sin = 1'b0;
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
      check("bp valid falls",   32'(dout_valid), 32'(0));
      check("bp overrun stays", 32'(overrun),    32'(1));
      step();
      check("bp overrun sticky", 32'(overrun),   32'(1));

      // Strobe gaps: sin_en alternates; opposite level driven on unsampled edges.
      dout_ready = 1'b1;
      do_reset();
      check("gap overrun cleared", 32'(overrun), 32'(0));
      d = 5'b10110;
      for (int i = 0; i < 7; i++) begin
         logic b;
         b = (i == 0) ? 1'b1 : (i == 6) ? 1'b0 : d[5 - i];
         sin = b; sin_en = 1'b1;
         step();
         if (i < 6) begin
            check($sformatf("gap%0d busy", i),  32'(busy),       32'(1));
            check($sformatf("gap%0d valid", i), 32'(dout_valid), 32'(0));
            sin = ~b; sin_en = 1'b0;
            step();
            check($sformatf("gap%0d hold busy", i),  32'(busy),       32'(1));
            check($sformatf("gap%0d hold valid", i), 32'(dout_valid), 32'(0));
         end
      end
      check("gap dout",  32'(dout),       32'(5'b10110));
      check("gap valid", 32'(dout_valid), 32'(1));
      check("gap busy",  32'(busy),       32'(0));
      sin = 1'b0; sin_en = 1'b0;
      step();
      check("gap valid consumed", 32'(dout_valid), 32'(0));

      // Reset mid-frame after three data bits.
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      check("rmf busy before", 32'(busy), 32'(1));
      sin = 1'b0;
      do_reset();
      check("rmf busy", 32'(busy), 32'(0));
      check("rmf valid", 32'(dout_valid), 32'(0));
      check("rmf dout", 32'(dout), 32'(0));
      for (int i = 0; i < 4; i++) begin
         send_bit(1'b0);
         check($sformatf("rmf idle%0d valid", i), 32'(dout_valid), 32'(0));
         check($sformatf("rmf idle%0d busy", i),  32'(busy),       32'(0));
      end
      send_frame(5'b11111, 1'b0, 1'b0);
      check("rmf clean dout",  32'(dout),       32'(5'b11111));
      check("rmf clean valid", 32'(dout_valid), 32'(1));

      // Bad stop bit with line left high: the next sampled 1 is a start bit.
      send_frame(5'b10110, 1'b1, 1'b0);
      check("hi frame_err", 32'(frame_err), 32'(1));
      check("hi valid",     32'(dout_valid), 32'(0));
      send_frame(5'b01010, 1'b0, 1'b0);
      check("hi next dout",  32'(dout),       32'(5'b01010));
      check("hi next valid", 32'(dout_valid), 32'(1));
      check("hi ferr clear", 32'(frame_err),  32'(0));

`ifdef SERIAL_DESER_PARITY_EN
      sin = 1'b0;
      send_bit(1'b0);
      send_frame(5'b10110, 1'b0, 1'b0);
      check("par good dout",  32'(dout),       32'(5'b10110));
      check("par good valid", 32'(dout_valid), 32'(1));
      check("par good perr",  32'(par_err),    32'(0));
      send_frame(5'b10110, 1'b0, 1'b1);
      check("par bad perr",   32'(par_err),    32'(1));
      check("par bad valid",  32'(dout_valid), 32'(0));
      send_bit(1'b0);
      check("par perr pulse", 32'(par_err),    32'(0));
      send_frame(5'b00101, 1'b1, 1'b1);
      check("par both ferr",  32'(frame_err),  32'(1));
      check("par both perr",  32'(par_err),    32'(0));
      check("par both valid", 32'(dout_valid), 32'(0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
